// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, derived totals, sync windows and
// the colour-bar palette shared by the sync generator.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT
                               + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT
                               + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // {R3,G3,B2} bars, left to right
    localparam logic [7:0] BAR_COLOURS [8] = '{
        8'h00, 8'h03, 8'h1C, 8'h1F,
        8'hE0, 8'hE3, 8'hFC, 8'hFF
    };

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N up counter with enable, synchronous active-high reset and
// terminal-count flag. Ports: clk, rst, en -> cnt[W-1:0], tc.
module vga_mod_counter
    import vga_timing_pkg::*;
#(
    parameter int N = DEF_H_TOTAL,
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: h/v counters, stage-1 coordinates/flags and
// stage-2 sync + blanked colour, aligned at the connector.
// Ports: clk_vs, rst_vs (sync, active-high), rgb_in[7:0]
//   -> pix_x, pix_y, video_on, frame_start (stage 1),
//      hsync_out, vsync_out, rgb_out (stage 2).
// Optional macro VGA_SYNC_TESTPAT_EN adds test_sel (colour bars).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic             clk_vs,
    input  logic             rst_vs,
    input  logic [7:0]       rgb_in,
`ifdef VGA_SYNC_TESTPAT_EN
    input  logic             test_sel,
`endif
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             video_on,
    output logic             frame_start,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [7:0]       rgb_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT
                                                   + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT
                                                   + V_SYNC);

    localparam logic ACT   = SYNC_POL;
    localparam logic INACT = ~SYNC_POL;

    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_timing
        $error("vga_sync_gen: timing totals exceed 10-bit counters");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_tc;
    logic             v_tc_unused;

    vga_mod_counter #(
        .N (H_TOTAL),
        .W (CNT_W)
    ) u_h_cnt (
        .clk (clk_vs),
        .rst (rst_vs),
        .en  (1'b1),
        .cnt (h_cnt),
        .tc  (h_tc)
    );

    vga_mod_counter #(
        .N (V_TOTAL),
        .W (CNT_W)
    ) u_v_cnt (
        .clk (clk_vs),
        .rst (rst_vs),
        .en  (h_tc),
        .cnt (v_cnt),
        .tc  (v_tc_unused)
    );

    logic [CNT_W-1:0] pix_x_d, pix_x_q;
    logic [CNT_W-1:0] pix_y_d, pix_y_q;
    logic             video_on_d, video_on_q;
    logic             frame_start_d, frame_start_q;
    logic             hs1_d, hs1_q;
    logic             vs1_d, vs1_q;
    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;
    logic [7:0]       rgb_d, rgb_q;
    logic [7:0]       colour;

    // Upstream colour is computed from stage-1 coordinates, so it is
    // valid in the same cycle as video_on_q.
`ifdef VGA_SYNC_TESTPAT_EN
    assign colour = test_sel ? BAR_COLOURS[pix_x_q[9:7]] : rgb_in;
`else
    assign colour = rgb_in;
`endif

    always_comb begin
        pix_x_d       = h_cnt;
        pix_y_d       = v_cnt;
        video_on_d    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        hs1_d         = INACT;
        vs1_d         = INACT;
        if (h_cnt >= HS_START && h_cnt < HS_END) begin
            hs1_d = ACT;
        end
        if (v_cnt >= VS_START && v_cnt < VS_END) begin
            vs1_d = ACT;
        end
        hsync_d = hs1_q;
        vsync_d = vs1_q;
        rgb_d   = video_on_q ? colour : 8'h00;
    end

    // Reset drives both sync stages inactive so no pulse survives it.
    always_ff @(posedge clk_vs) begin
        if (rst_vs) begin
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            hs1_q         <= INACT;
            vs1_q         <= INACT;
            hsync_q       <= INACT;
            vsync_q       <= INACT;
            rgb_q         <= 8'h00;
        end else begin
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: linear-position reference model
// plus directed measurements of sync widths, strobe spacing and blanking.
module tb_vga_sync_gen;

    localparam int HT  = 800;
    localparam int VV  = 12;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int VT  = VV + VF + VS + VB;
    localparam int FT  = HT * VT;

    logic       clk;
    logic       rst;
    logic [7:0] rgb_in;
    logic       test_sel;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       frame_start;
    logic       hsync_out;
    logic       vsync_out;
    logic [7:0] rgb_out;

    vga_sync_gen #(
        .V_VISIBLE (VV),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB)
    ) dut (
        .clk_vs      (clk),
        .rst_vs      (rst),
        .rgb_in      (rgb_in),
`ifdef VGA_SYNC_TESTPAT_EN
        .test_sel    (test_sel),
`endif
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .video_on    (video_on),
        .frame_start (frame_start),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .rgb_out     (rgb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] bars_tb [8] = '{
        8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF
    };

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model: pos is the linear counter position in the frame
    int   pos;
    int   e_x, e_y;
    logic e_von, e_fs, e_hs1, e_vs1, e_hs2, e_vs2;
    logic [7:0] e_rgb;

    // trackers
    int   last_fs = -1;
    int   last_px0 = -1;
    int   last_hfall = -1;
    int   hs_len = 0;
    int   vs_len = 0;
    bit   hs_run = 0;
    bit   vs_run = 0;
    bit   ff_mode = 0;
    bit   ff_armed = 0;
    int   ff_len = 0;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    logic prev_fs = 1'b0;
    logic prev_von = 1'b0;
    int   prev_py = 0;
    int   prev_px = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        logic       r;
        int         p;
        logic [7:0] ri;
        logic       ts;
        int         x, y;
        r  = rst;
        p  = pos;
        ri = rgb_in;
        ts = 1'b0;
`ifdef VGA_SYNC_TESTPAT_EN
        ts = test_sel;
`endif
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            pos   = 0;
            e_x   = 0;
            e_y   = 0;
            e_von = 1'b0;
            e_fs  = 1'b0;
            e_hs1 = 1'b0;
            e_vs1 = 1'b0;
            e_hs2 = 1'b0;
            e_vs2 = 1'b0;
            e_rgb = 8'h00;
        end else begin
            e_rgb = e_von ? (ts ? bars_tb[e_x / 128] : ri) : 8'h00;
            e_hs2 = e_hs1;
            e_vs2 = e_vs1;
            x     = p % HT;
            y     = p / HT;
            e_x   = x;
            e_y   = y;
            e_von = (x < 640) && (y < VV);
            e_fs  = (p == 0);
            e_hs1 = (x >= 656) && (x < 752);
            e_vs1 = (y >= VV + VF) && (y < VV + VF + VS);
            pos   = (p + 1) % FT;
        end

        chk("pix_x", 32'(pix_x), 32'(e_x));
        chk("pix_y", 32'(pix_y), 32'(e_y));
        chk("video_on", 32'(video_on), 32'(e_von));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("hsync_out", 32'(hsync_out), 32'(!e_hs2));
        chk("vsync_out", 32'(vsync_out), 32'(!e_vs2));
        chk("rgb_out", 32'(rgb_out), 32'(e_rgb));

        if (r) begin
            last_fs    = -1;
            last_hfall = -1;
            hs_run     = 0;
            vs_run     = 0;
        end

        if (frame_start === 1'b1) begin
            chk("fs_width", 32'(prev_fs), 32'(0));
            if (last_fs >= 0) chk("fs_spacing", 32'(cyc - last_fs), 32'(FT));
            last_fs = cyc;
        end

        if (pix_x === 10'd0) last_px0 = cyc;

        if (prev_hs === 1'b1 && hsync_out === 1'b0) begin
            if (last_px0 >= 0)
                chk("hs_fall_pos", 32'(cyc - last_px0), 32'(657));
            if (last_hfall >= 0)
                chk("line_period", 32'(cyc - last_hfall), 32'(HT));
            last_hfall = cyc;
            hs_run = 1;
            hs_len = 1;
        end else if (hsync_out === 1'b0) begin
            hs_len++;
        end else if (prev_hs === 1'b0 && hs_run) begin
            chk("hs_width", 32'(hs_len), 32'(96));
            hs_run = 0;
        end

        if (prev_vs === 1'b1 && vsync_out === 1'b0) begin
            vs_run = 1;
            vs_len = 1;
        end else if (vsync_out === 1'b0) begin
            vs_len++;
        end else if (prev_vs === 1'b0 && vs_run) begin
            chk("vs_width", 32'(vs_len), 32'(2 * HT));
            vs_run = 0;
        end

        if (prev_py == VT - 1 && int'(pix_y) != VT - 1)
            chk("py_wrap", 32'(pix_y), 32'(0));

        if (ff_mode) begin
            if (rgb_out === 8'hFF) begin
                if (ff_armed) ff_len++;
            end else begin
                if (ff_armed && ff_len > 0) chk("ff_run", 32'(ff_len), 32'(640));
                ff_armed = 1;
                ff_len   = 0;
            end
        end

        if (ts && prev_von === 1'b1)
            chk("bar", 32'(rgb_out), 32'(bars_tb[prev_px / 128]));

        prev_hs  = hsync_out;
        prev_vs  = vsync_out;
        prev_fs  = frame_start;
        prev_von = video_on;
        prev_py  = int'(pix_y);
        prev_px  = int'(pix_x);
    endtask

    initial begin
        bit found;
        rst      = 1'b1;
        rgb_in   = 8'h00;
        test_sel = 1'b0;

        repeat (5) tick();
        chk("rst_hsync", 32'(hsync_out), 32'(1));
        chk("rst_vsync", 32'(vsync_out), 32'(1));
        chk("rst_rgb", 32'(rgb_out), 32'(0));
        chk("rst_fs", 32'(frame_start), 32'(0));

        rst = 1'b0;
        tick();
        chk("rel_fs", 32'(frame_start), 32'(1));
        chk("rel_px", 32'(pix_x), 32'(0));
        rgb_in = 8'($urandom);
        tick();
        chk("rel_fs_off", 32'(frame_start), 32'(0));

        // two frames plus a line of random colour
        for (int i = 0; i < 2 * FT + HT; i++) begin
            rgb_in = 8'($urandom);
            tick();
        end

        // solid white input
        rgb_in  = 8'hFF;
        ff_mode = 1;
        repeat (3 * HT) tick();
        ff_mode = 0;

        // reset in the middle of an hsync pulse
        found = 0;
        for (int i = 0; i < FT + 10 && !found; i++) begin
            rgb_in = 8'($urandom);
            tick();
            if (pix_x === 10'd700 && pix_y === 10'd10) found = 1;
        end
        chk("wait_700_10", 32'(found), 32'(1));
        rst = 1'b1;
        tick();
        chk("mid_rst_hs1", 32'(hsync_out), 32'(1));
        chk("mid_rst_px", 32'(pix_x), 32'(0));
        rst = 1'b0;
        tick();
        chk("mid_rst_fs", 32'(frame_start), 32'(1));
        chk("mid_rst_hs2", 32'(hsync_out), 32'(1));
        chk("mid_rst_py", 32'(pix_y), 32'(0));
        for (int i = 0; i < 2 * HT; i++) begin
            rgb_in = 8'($urandom);
            tick();
        end

`ifdef VGA_SYNC_TESTPAT_EN
        test_sel = 1'b1;
        for (int i = 0; i < 2 * HT; i++) begin
            rgb_in = 8'($urandom);
            tick();
        end
        test_sel = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
